// File: rtl/ppu_vout_align_pkg.sv
// Shared video parameter package for the PPU video output aligner.
// Holds the sync bit positions inside vdata_i, the filter-select and
// filter-code constants, the aligner FSM state enum and the helper that
// maps a filter selection to the {F1,F2} code driven on the filter pins.
package ppu_vout_align_pkg;

    // Bit positions of the sync nibble at the bottom of vdata_i.
    localparam int SYNC_NCSYNC = 0;
    localparam int SYNC_NHSYNC = 1;
    localparam int SYNC_NBLANK = 2;
    localparam int SYNC_NVSYNC = 3;
    localparam int SYNC_W      = 4;

    // filter_set_i encodings.
    localparam logic [1:0] FSET_AUTO   = 2'b00;
    localparam logic [1:0] FSET_9M5    = 2'b01;
    localparam logic [1:0] FSET_18M    = 2'b10;
    localparam logic [1:0] FSET_BYPASS = 2'b11;

    // Filter codes as {F1,F2}.
    localparam logic [1:0] FCODE_9M5    = 2'b00;
    localparam logic [1:0] FCODE_18M    = 2'b01;
    localparam logic [1:0] FCODE_BYPASS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } vout_state_e;

    // Auto mode picks the wider filter when lines are doubled, since the
    // pixel rate doubles as well.
    function automatic logic [1:0] filter_code(input logic [1:0] fset,
                                               input logic       linedbl);
        logic [1:0] code;
        case (fset)
            FSET_BYPASS: code = FCODE_BYPASS;
            FSET_18M:    code = FCODE_18M;
            FSET_9M5:    code = FCODE_9M5;
            default:     code = linedbl ? FCODE_18M : FCODE_9M5;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ppu_vout_align_if.sv
// Video bus interface of the PPU video output aligner.
//   vdata_i      : {colour, sync[3:0]} from the pixel pipeline
//   VD_o         : aligned colour
//   nCSYNC       : {nCSYNC, ADV712x nCSYNC}
//   nVSYNC_or_F2 : VGA vsync or filter bit F2
//   nHSYNC_or_F1 : VGA hsync or filter bit F1
// master = video source / sink side, slave = aligner.
interface ppu_vout_align_if #(
    parameter int NCH = 3,
    parameter int CW  = 8
);
    logic [4+NCH*CW-1:0] vdata_i;
    logic [NCH*CW-1:0]   VD_o;
    logic [1:0]          nCSYNC;
    logic                nVSYNC_or_F2;
    logic                nHSYNC_or_F1;

    modport master (
        output vdata_i,
        input  VD_o, nCSYNC, nVSYNC_or_F2, nHSYNC_or_F1
    );

    modport slave (
        input  vdata_i,
        output VD_o, nCSYNC, nVSYNC_or_F2, nHSYNC_or_F1
    );
endinterface

// File: rtl/vout_delay_line.sv
// Circular delay buffer with DEPTH entries of W bits.
//   clk, srst : clock and synchronous active-high reset (pointers, output)
//   din       : sample written every cycle
//   dly       : extra delay D (0..DEPTH-1)
//   dout      : din delayed by 1+D cycles (registered read)
// Storage itself is not reset so it can map onto RAM.
module vout_delay_line #(
    parameter int W     = 8,
    parameter int DEPTH = 5
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic [W-1:0]             din,
    input  logic [$clog2(DEPTH)-1:0] dly,
    output logic [W-1:0]             dout
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr;
    logic [W-1:0]  dout_q;

    // Read pointer trails the write pointer by D, wrapping modulo DEPTH.
    // For power-of-two depths PW'(DEPTH) is zero and natural wrap applies.
    always_comb begin
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (wr_ptr_q >= dly) begin
            rd_ptr = wr_ptr_q - dly;
        end else begin
            rd_ptr = wr_ptr_q + PW'(DEPTH) - dly;
        end
    end

    always_ff @(posedge clk) begin
        mem[wr_ptr_q] <= din;
    end

    // With D=0 the read slot is the one being written, so forward din.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            dout_q   <= (dly == '0) ? din : mem[rd_ptr];
        end
    end

    assign dout = dout_q;
endmodule

// File: rtl/ppu_vout_align.sv
// PPU video output aligner.
// Registers the sync nibble once, delays colour by 1+D cycles through a
// circular buffer, blanks colour while the buffer refills after a delay
// change, and drives the ADV712x csync and the VGA-sync / filter-code pins.
// Ports:
//   VCLK, VRST        : video clock, synchronous active-high reset
//   bus (slave)       : vdata_i in; VD_o, nCSYNC, nVSYNC_or_F2, nHSYNC_or_F1 out
//   delay_i           : requested extra colour delay (clamped to MAX_DELAY)
//   filter_set_i      : 00 auto, 01 9.5 MHz, 10 18 MHz, 11 bypass
//   linedbl_en_i      : line doubling active (auto filter choice)
//   use_vga_hvsync_i  : 1 = sync on the shared pins, 0 = filter code
//   csync2_en_i       : enables the ADV712x csync output
//   busy_o            : buffer refill in progress
//   delay_err_o       : sticky, delay_i exceeded MAX_DELAY
// Optional feature macro VOUT_BLANK_EN: forces colour to zero wherever the
// delayed nBLANK is low; without it no nBLANK delay storage is built.
module ppu_vout_align
    import ppu_vout_align_pkg::*;
#(
    parameter int NCH       = 3,
    parameter int CW        = 8,
    parameter int MAX_DELAY = 4
) (
    input  logic             VCLK,
    input  logic             VRST,
    ppu_vout_align_if.slave  bus,
    input  logic [3:0]       delay_i,
    input  logic [1:0]       filter_set_i,
    input  logic             linedbl_en_i,
    input  logic             use_vga_hvsync_i,
    input  logic             csync2_en_i,
    output logic             busy_o,
    output logic             delay_err_o
);
    localparam int CDW   = NCH * CW;
    localparam int DEPTH = MAX_DELAY + 1;
    localparam int PW    = $clog2(DEPTH);
`ifdef VOUT_BLANK_EN
    localparam int DLW   = CDW + 1;
`else
    localparam int DLW   = CDW;
`endif

    vout_state_e         state_q, state_d;
    logic [PW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       d_lat_q, d_lat_d;
    logic [SYNC_W-1:0]   sync_q, sync_d;
    logic [1:0]          fcode_q, fcode_d;
    logic                err_q, err_d;

    logic                delay_over;
    logic [PW-1:0]       d_eff;
    logic                vs_fall;
    logic [DLW-1:0]      dl_in;
    logic [DLW-1:0]      dl_out;
    logic                blank_ok;
    logic                sync_blank_unused;

    assign delay_over = (delay_i > 4'(MAX_DELAY));
    assign d_eff      = delay_over ? PW'(MAX_DELAY) : PW'(delay_i);

    // Falls on the same edge at which sync_q[nVSYNC] goes from 1 to 0.
    assign vs_fall = sync_q[SYNC_NVSYNC] & ~bus.vdata_i[SYNC_NVSYNC];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_lat_d = d_lat_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FILL;
                d_lat_d = d_eff;
                cnt_d   = '0;
            end
            ST_FILL: begin
                if (d_eff != d_lat_q) begin
                    d_lat_d = d_eff;
                    cnt_d   = '0;
                end else if (cnt_q == d_lat_q) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (d_eff != d_lat_q) begin
                    state_d = ST_FILL;
                    d_lat_d = d_eff;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        sync_d  = bus.vdata_i[SYNC_W-1:0];
        fcode_d = vs_fall ? filter_code(filter_set_i, linedbl_en_i) : fcode_q;
        err_d   = err_q | delay_over;
    end

    always_ff @(posedge VCLK) begin
        if (VRST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            d_lat_q <= '0;
            sync_q  <= '0;
            fcode_q <= FCODE_9M5;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_lat_q <= d_lat_d;
            sync_q  <= sync_d;
            fcode_q <= fcode_d;
            err_q   <= err_d;
        end
    end

`ifdef VOUT_BLANK_EN
    // nBLANK travels alongside the colour so it sees the same 1+D delay.
    assign dl_in    = {bus.vdata_i[SYNC_NBLANK], bus.vdata_i[CDW+SYNC_W-1:SYNC_W]};
    assign blank_ok = dl_out[CDW];
`else
    assign dl_in    = bus.vdata_i[CDW+SYNC_W-1:SYNC_W];
    assign blank_ok = 1'b1;
`endif

    // The registered nBLANK has no consumer of its own.
    assign sync_blank_unused = sync_q[SYNC_NBLANK];

    vout_delay_line #(
        .W     (DLW),
        .DEPTH (DEPTH)
    ) u_delay (
        .clk  (VCLK),
        .srst (VRST),
        .din  (dl_in),
        .dly  (d_eff),
        .dout (dl_out)
    );

    assign bus.VD_o = (state_q == ST_RUN && blank_ok) ? dl_out[CDW-1:0] : '0;
    assign bus.nCSYNC = {sync_q[SYNC_NCSYNC], csync2_en_i & sync_q[SYNC_NCSYNC]};
    assign bus.nVSYNC_or_F2 = use_vga_hvsync_i ? sync_q[SYNC_NVSYNC] : fcode_q[0];
    assign bus.nHSYNC_or_F1 = use_vga_hvsync_i ? sync_q[SYNC_NHSYNC] : fcode_q[1];
    assign busy_o      = (state_q != ST_RUN);
    assign delay_err_o = err_q;
endmodule

// File: tb/tb_ppu_vout_align.sv
// Directed testbench for ppu_vout_align (NCH=3, CW=8, MAX_DELAY=4).
// Colour driven in cycle k is col(k); sync driven in cycle k is logged in
// sync_hist so expected outputs come from the bench's own record.
module tb_ppu_vout_align;
    localparam int NCH  = 3;
    localparam int CW   = 8;
    localparam int MAXD = 4;

    logic VCLK = 1'b0;
    logic VRST = 1'b1;
    always #5 VCLK = ~VCLK;

    ppu_vout_align_if #(.NCH(NCH), .CW(CW)) vif ();

    logic [3:0] delay_i;
    logic [1:0] filter_set_i;
    logic       linedbl_en_i;
    logic       use_vga_hvsync_i;
    logic       csync2_en_i;
    logic       busy_o;
    logic       delay_err_o;

    ppu_vout_align #(.NCH(NCH), .CW(CW), .MAX_DELAY(MAXD)) dut (
        .VCLK             (VCLK),
        .VRST             (VRST),
        .bus              (vif),
        .delay_i          (delay_i),
        .filter_set_i     (filter_set_i),
        .linedbl_en_i     (linedbl_en_i),
        .use_vga_hvsync_i (use_vga_hvsync_i),
        .csync2_en_i      (csync2_en_i),
        .busy_o           (busy_o),
        .delay_err_o      (delay_err_o)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [3:0] sync_v;
    logic [3:0] sync_hist [4096];

    function automatic logic [23:0] col(input int k);
        logic [7:0] b;
        b = k[7:0];
        return {b, ~b, b ^ 8'h5A};
    endfunction

    function automatic logic [3:0] sync_at(input int k);
        return sync_hist[k & 4095];
    endfunction

    task automatic drive();
        vif.vdata_i = {col(cyc), sync_v};
        sync_hist[cyc & 4095] = sync_v;
    endtask

    task automatic step();
        @(posedge VCLK);
        #1;
        cyc++;
        drive();
    endtask

    // Steps while busy_o is high; reports how many busy cycles were seen and
    // whether any of them showed non-zero colour. Bounded at 40 cycles.
    task automatic wait_run(output int n, output bit vd_nz);
        n = 0;
        vd_nz = 1'b0;
        while (busy_o === 1'b1 && n < 40) begin
            if (vif.VD_o !== '0) vd_nz = 1'b1;
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        VRST = 1'b1;
        delay_i = 4'd0;
        filter_set_i = 2'b00;
        linedbl_en_i = 1'b0;
        use_vga_hvsync_i = 1'b0;
        csync2_en_i = 1'b1;
        sync_v = 4'hF;
        drive();
        repeat (3) step();
        n_vec++; if (vif.VD_o !== 24'h0) begin n_err++; $display("FAIL rst_vd: got %h want 000000", vif.VD_o); end
        n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b want 1", busy_o); end
        n_vec++; if (delay_err_o !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", delay_err_o); end
        n_vec++; if (vif.nCSYNC !== 2'b00) begin n_err++; $display("FAIL rst_csync: got %b want 00", vif.nCSYNC); end
        n_vec++; if ({vif.nHSYNC_or_F1, vif.nVSYNC_or_F2} !== 2'b00) begin n_err++; $display("FAIL rst_fpins: got %b%b want 00", vif.nHSYNC_or_F1, vif.nVSYNC_or_F2); end
        use_vga_hvsync_i = 1'b1;
        #1;
        n_vec++; if ({vif.nHSYNC_or_F1, vif.nVSYNC_or_F2} !== 2'b00) begin n_err++; $display("FAIL rst_vgapins: got %b%b want 00", vif.nHSYNC_or_F1, vif.nVSYNC_or_F2); end
        use_vga_hvsync_i = 1'b0;
    endtask

    task automatic test_zero_delay();
        int n;
        bit nz;
        logic [3:0] s;
        VRST = 1'b0;
        wait_run(n, nz);
        n_vec++; if (n !== 2) begin n_err++; $display("FAIL d0_busy_len: got %0d want 2", n); end
        n_vec++; if (nz !== 1'b0) begin n_err++; $display("FAIL d0_vd_fill: got nonzero want 0"); end
        use_vga_hvsync_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sync_v = 4'(i * 5 + 3);
            drive();
            step();
            s = sync_at(cyc - 1);
            n_vec++; if (vif.VD_o !== col(cyc - 1)) begin n_err++; $display("FAIL d0_vd: got %h want %h", vif.VD_o, col(cyc - 1)); end
            n_vec++; if ({vif.nVSYNC_or_F2, vif.nHSYNC_or_F1, vif.nCSYNC} !== {s[3], s[1], s[0], s[0]}) begin
                n_err++; $display("FAIL d0_sync: got %b%b%b want %b%b%b%b", vif.nVSYNC_or_F2, vif.nHSYNC_or_F1, vif.nCSYNC, s[3], s[1], s[0], s[0]);
            end
        end
    endtask

    task automatic test_delay_change();
        int n;
        bit nz;
        logic [3:0] s;
        delay_i = 4'd3;
        step();
        wait_run(n, nz);
        n_vec++; if (n !== 4) begin n_err++; $display("FAIL d3_busy_len: got %0d want 4", n); end
        n_vec++; if (nz !== 1'b0) begin n_err++; $display("FAIL d3_vd_fill: got nonzero want 0"); end
        for (int i = 0; i < 6; i++) begin
            sync_v = 4'(i * 7 + 1);
            drive();
            step();
            s = sync_at(cyc - 1);
            n_vec++; if (vif.VD_o !== col(cyc - 4)) begin n_err++; $display("FAIL d3_vd: got %h want %h", vif.VD_o, col(cyc - 4)); end
            n_vec++; if ({vif.nVSYNC_or_F2, vif.nHSYNC_or_F1} !== {s[3], s[1]}) begin
                n_err++; $display("FAIL d3_sync: got %b%b want %b%b", vif.nVSYNC_or_F2, vif.nHSYNC_or_F1, s[3], s[1]);
            end
        end
    endtask

    task automatic test_delay_err();
        int n;
        bit nz;
        delay_i = 4'd9;
        step();
        n_vec++; if (delay_err_o !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", delay_err_o); end
        wait_run(n, nz);
        n_vec++; if (n !== 5) begin n_err++; $display("FAIL err_busy_len: got %0d want 5", n); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if (vif.VD_o !== col(cyc - 5)) begin n_err++; $display("FAIL err_vd5: got %h want %h", vif.VD_o, col(cyc - 5)); end
        end
        delay_i = 4'd2;
        step();
        wait_run(n, nz);
        n_vec++; if (n !== 3) begin n_err++; $display("FAIL d2_busy_len: got %0d want 3", n); end
        n_vec++; if (delay_err_o !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", delay_err_o); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if (vif.VD_o !== col(cyc - 3)) begin n_err++; $display("FAIL d2_vd3: got %h want %h", vif.VD_o, col(cyc - 3)); end
        end
    endtask

    task automatic test_filter();
        use_vga_hvsync_i = 1'b0;
        csync2_en_i = 1'b0;
        filter_set_i = 2'b00;
        linedbl_en_i = 1'b0;
        sync_v = 4'hF;
        drive();
        step();
        step();
        n_vec++; if ({vif.nHSYNC_or_F1, vif.nVSYNC_or_F2} !== 2'b00) begin n_err++; $display("FAIL flt_init: got %b%b want 00", vif.nHSYNC_or_F1, vif.nVSYNC_or_F2); end
        filter_set_i = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if ({vif.nHSYNC_or_F1, vif.nVSYNC_or_F2} !== 2'b00) begin n_err++; $display("FAIL flt_hold: got %b%b want 00", vif.nHSYNC_or_F1, vif.nVSYNC_or_F2); end
        end
        sync_v = 4'h7;
        drive();
        step();
        n_vec++; if ({vif.nHSYNC_or_F1, vif.nVSYNC_or_F2} !== 2'b01) begin n_err++; $display("FAIL flt_18m: got %b%b want 01", vif.nHSYNC_or_F1, vif.nVSYNC_or_F2); end
        n_vec++; if (vif.nCSYNC !== 2'b10) begin n_err++; $display("FAIL csync2_off: got %b want 10", vif.nCSYNC); end
        sync_v = 4'hF;
        drive();
        step();
        filter_set_i = 2'b01;
        step();
        filter_set_i = 2'b11;
        step();
        n_vec++; if ({vif.nHSYNC_or_F1, vif.nVSYNC_or_F2} !== 2'b01) begin n_err++; $display("FAIL flt_pending: got %b%b want 01", vif.nHSYNC_or_F1, vif.nVSYNC_or_F2); end
        sync_v = 4'h7;
        drive();
        step();
        n_vec++; if ({vif.nHSYNC_or_F1, vif.nVSYNC_or_F2} !== 2'b11) begin n_err++; $display("FAIL flt_latest: got %b%b want 11", vif.nHSYNC_or_F1, vif.nVSYNC_or_F2); end
        sync_v = 4'hF;
        drive();
        filter_set_i = 2'b00;
        linedbl_en_i = 1'b1;
        step();
        step();
        sync_v = 4'h7;
        drive();
        step();
        n_vec++; if ({vif.nHSYNC_or_F1, vif.nVSYNC_or_F2} !== 2'b01) begin n_err++; $display("FAIL flt_auto_ld: got %b%b want 01", vif.nHSYNC_or_F1, vif.nVSYNC_or_F2); end
        sync_v = 4'hF;
        drive();
        step();
        csync2_en_i = 1'b1;
    endtask

    task automatic test_reset_fill();
        int n;
        bit nz;
        delay_i = 4'd0;
        step();
        wait_run(n, nz);
        delay_i = 4'd2;
        step();
        n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL rf_fill: got %b want 1", busy_o); end
        VRST = 1'b1;
        step();
        n_vec++; if (vif.VD_o !== 24'h0) begin n_err++; $display("FAIL rf_vd: got %h want 000000", vif.VD_o); end
        n_vec++; if (delay_err_o !== 1'b0) begin n_err++; $display("FAIL rf_err: got %b want 0", delay_err_o); end
        n_vec++; if (vif.nCSYNC !== 2'b00) begin n_err++; $display("FAIL rf_csync: got %b want 00", vif.nCSYNC); end
        n_vec++; if ({vif.nHSYNC_or_F1, vif.nVSYNC_or_F2} !== 2'b00) begin n_err++; $display("FAIL rf_fpins: got %b%b want 00", vif.nHSYNC_or_F1, vif.nVSYNC_or_F2); end
        VRST = 1'b0;
        wait_run(n, nz);
        n_vec++; if (n !== 4) begin n_err++; $display("FAIL rf_busy_len: got %0d want 4", n); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (vif.VD_o !== col(cyc - 3)) begin n_err++; $display("FAIL rf_vd3: got %h want %h", vif.VD_o, col(cyc - 3)); end
        end
    endtask

`ifdef VOUT_BLANK_EN
    task automatic test_blank();
        int n;
        bit nz;
        int zeros;
        logic [23:0] exp_vd;
        delay_i = 4'd1;
        step();
        wait_run(n, nz);
        zeros = 0;
        for (int i = 0; i < 20; i++) begin
            sync_v = (i >= 4 && i < 14) ? 4'hB : 4'hF;
            drive();
            step();
            exp_vd = sync_at(cyc - 2)[2] ? col(cyc - 2) : 24'h0;
            if (vif.VD_o === 24'h0) zeros++;
            n_vec++; if (vif.VD_o !== exp_vd) begin n_err++; $display("FAIL blank_vd: got %h want %h", vif.VD_o, exp_vd); end
        end
        n_vec++; if (zeros !== 10) begin n_err++; $display("FAIL blank_len: got %0d want 10", zeros); end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_delay();
        test_delay_change();
        test_delay_err();
        test_filter();
        test_reset_fill();
`ifdef VOUT_BLANK_EN
        test_blank();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
